game_countdown_timer: RTL and testbench



---
 rtl/game_timer_pkg.sv | 68 ++++++
 rtl/game_countdown_timer_tick_sync.sv | 30 +++
 rtl/game_countdown_timer.sv | 128 ++++++++++++
 tb/tb_game_countdown_timer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types, constants and BCD arithmetic helpers for the game round countdown timer.
package game_timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

  // One-second BCD borrow cascade; 00:00 is a floor, never an underflow.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t != '0) begin
      if (t.sec_ones != 4'd0) begin
        r.sec_ones = t.sec_ones - 4'd1;
      end else begin
        r.sec_ones = DIGIT_MAX;
        if (t.sec_tens != 4'd0) begin
          r.sec_tens = t.sec_tens - 4'd1;
        end else begin
          r.sec_tens = SEC_TENS_MAX;
          if (t.min_ones != 4'd0) begin
            r.min_ones = t.min_ones - 4'd1;
          end else begin
            r.min_ones = DIGIT_MAX;
            r.min_tens = t.min_tens - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // +10 s with carry into the minutes, saturating at 99:59.
  function automatic bcd_time_t bcd_add10(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_tens != SEC_TENS_MAX) begin
      r.sec_tens = t.sec_tens + 4'd1;
    end else if (t.min_tens == DIGIT_MAX && t.min_ones == DIGIT_MAX) begin
      r.sec_tens = SEC_TENS_MAX;
      r.sec_ones = DIGIT_MAX;
    end else begin
      r.sec_tens = 4'd0;
      if (t.min_ones == DIGIT_MAX) begin
        r.min_ones = 4'd0;
        r.min_tens = t.min_tens + 4'd1;
      end else begin
        r.min_ones = t.min_ones + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_countdown_timer_tick_sync.sv
// Synchronizes the once-per-second divider toggle and emits a one-cycle tick on
// every level change; reusable by any once-per-second consumer.
module timer_tick_sync (
  input  logic clk_25MHz,
  input  logic reset,
  input  logic i_toggle,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= i_toggle;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign o_tick = r_sync2 ^ r_hist;

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer: MM:SS BCD countdown driven by a once-per-second toggle.
// Optional low-time indicator enabled by defining GAME_TIMER_WARN_EN.
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int START_MIN = 2,
  parameter int START_SEC = 0,
  parameter int WARN_SEC  = 10
) (
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic               sec_toggle,
  input  logic               start,
  input  logic               pause,
  input  logic               bonus,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               time_up,
  output logic               expired_pulse,
  output logic               warn
);

  localparam bcd_time_t PRELOAD = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                   4'(START_SEC / 10), 4'(START_SEC % 10)};

  state_t    r_state;
  state_t    w_state_nxt;
  bcd_time_t r_time;
  bcd_time_t w_time_nxt;
  bcd_time_t w_after_tick;
  bcd_time_t w_run_time;
  bcd_time_t w_bonus_time;
  logic      w_tick;
  logic      r_running, r_time_up, r_expired_pulse, r_warn;
  logic      w_running_nxt, w_time_up_nxt, w_expired_pulse_nxt, w_warn_nxt;

  timer_tick_sync u_tick_sync (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .i_toggle  (sec_toggle),
    .o_tick    (w_tick)
  );

  // In RUN the decrement is applied first, then any bonus, within one edge.
  assign w_after_tick = w_tick ? bcd_dec(r_time) : r_time;
  assign w_run_time   = bonus ? bcd_add10(w_after_tick) : w_after_tick;
  assign w_bonus_time = bcd_add10(r_time);

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_time          <= PRELOAD;
      r_running       <= 1'b0;
      r_time_up       <= 1'b0;
      r_expired_pulse <= 1'b0;
      r_warn          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_time          <= w_time_nxt;
      r_running       <= w_running_nxt;
      r_time_up       <= w_time_up_nxt;
      r_expired_pulse <= w_expired_pulse_nxt;
      r_warn          <= w_warn_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    case (r_state)
      IDLE, EXPIRED: begin
        if (start) begin
          w_state_nxt = RUN;
          w_time_nxt  = PRELOAD;
        end
      end
      RUN: begin
        if (pause) begin
          w_state_nxt = PAUSE;
          w_time_nxt  = bonus ? w_bonus_time : r_time;
        end else begin
          w_time_nxt = w_run_time;
          if (w_tick && w_run_time == '0) w_state_nxt = EXPIRED;
        end
      end
      PAUSE: begin
        if (pause) w_state_nxt = RUN;
        if (bonus) w_time_nxt = w_bonus_time;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_running_nxt       = (w_state_nxt == RUN);
    w_time_up_nxt       = (w_state_nxt == EXPIRED);
    w_expired_pulse_nxt = (w_state_nxt == EXPIRED) && (r_state != EXPIRED);
  end

`ifdef GAME_TIMER_WARN_EN
  localparam logic [DIGIT_W-1:0] WARN_TENS = 4'(WARN_SEC / 10);
  localparam logic [DIGIT_W-1:0] WARN_ONES = 4'(WARN_SEC % 10);

  logic w_sec_le_warn;
  assign w_sec_le_warn = (w_time_nxt.sec_tens < WARN_TENS) ||
                         (w_time_nxt.sec_tens == WARN_TENS && w_time_nxt.sec_ones <= WARN_ONES);
  assign w_warn_nxt    = (w_state_nxt == RUN || w_state_nxt == PAUSE) &&
                         w_time_nxt.min_tens == 4'd0 && w_time_nxt.min_ones == 4'd0 &&
                         w_sec_le_warn;
`else
  assign w_warn_nxt = 1'b0;
`endif

  assign min_tens      = r_time.min_tens;
  assign min_ones      = r_time.min_ones;
  assign sec_tens      = r_time.sec_tens;
  assign sec_ones      = r_time.sec_ones;
  assign running       = r_running;
  assign time_up       = r_time_up;
  assign expired_pulse = r_expired_pulse;
  assign warn          = r_warn;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed self-checking bench for game_countdown_timer (main 02:00 preload, a
// 00:00 preload and a 99:55 preload instance sharing clock, reset and toggle).
module tb_game_countdown_timer;

`ifdef GAME_TIMER_WARN_EN
  localparam logic WARN_ON = 1'b1;
`else
  localparam logic WARN_ON = 1'b0;
`endif

  logic clk_25MHz = 1'b0;
  logic reset = 1'b1;
  logic sec_toggle = 1'b0;
  logic start = 1'b0, pause = 1'b0, bonus = 1'b0;
  logic start_z = 1'b0, start_s = 1'b0, bonus_s = 1'b0;

  logic [3:0] mt, mo, st, so, zmt, zmo, zst, zso, smt, smo, sst, sso;
  logic running, time_up, expired_pulse, warn;
  logic z_running, z_time_up, z_expired_pulse, z_warn;
  logic s_running, s_time_up, s_expired_pulse, s_warn;

  int n_tests = 0;
  int n_fail  = 0;

  always #20 clk_25MHz = ~clk_25MHz;

  game_countdown_timer #(.START_MIN(2), .START_SEC(0), .WARN_SEC(10)) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .sec_toggle(sec_toggle),
    .start(start), .pause(pause), .bonus(bonus),
    .min_tens(mt), .min_ones(mo), .sec_tens(st), .sec_ones(so),
    .running(running), .time_up(time_up), .expired_pulse(expired_pulse), .warn(warn));

  game_countdown_timer #(.START_MIN(0), .START_SEC(0), .WARN_SEC(10)) dut_z (
    .clk_25MHz(clk_25MHz), .reset(reset), .sec_toggle(sec_toggle),
    .start(start_z), .pause(1'b0), .bonus(1'b0),
    .min_tens(zmt), .min_ones(zmo), .sec_tens(zst), .sec_ones(zso),
    .running(z_running), .time_up(z_time_up), .expired_pulse(z_expired_pulse), .warn(z_warn));

  game_countdown_timer #(.START_MIN(99), .START_SEC(55), .WARN_SEC(10)) dut_s (
    .clk_25MHz(clk_25MHz), .reset(reset), .sec_toggle(sec_toggle),
    .start(start_s), .pause(1'b0), .bonus(bonus_s),
    .min_tens(smt), .min_ones(smo), .sec_tens(sst), .sec_ones(sso),
    .running(s_running), .time_up(s_time_up), .expired_pulse(s_expired_pulse), .warn(s_warn));

  wire [15:0] digits   = {mt, mo, st, so};
  wire [15:0] z_digits = {zmt, zmo, zst, zso};
  wire [15:0] s_digits = {smt, smo, sst, sso};

  // One second: flip the toggle, then allow the sync chain and the update to settle.
  task automatic one_second();
    @(negedge clk_25MHz) sec_toggle = ~sec_toggle;
    repeat (5) @(negedge clk_25MHz);
  endtask

  task automatic seconds(input int n);
    for (int i = 0; i < n; i++) one_second();
  endtask

  task automatic pulse_start();
    @(negedge clk_25MHz) start = 1'b1;
    @(negedge clk_25MHz) start = 1'b0;
  endtask

  task automatic pulse_pause();
    @(negedge clk_25MHz) pause = 1'b1;
    @(negedge clk_25MHz) pause = 1'b0;
  endtask

  task automatic pulse_bonus();
    @(negedge clk_25MHz) bonus = 1'b1;
    @(negedge clk_25MHz) bonus = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_25MHz);
    n_tests++; if (digits !== 16'h0200) begin n_fail++; $display("FAIL reset_digits got %h want 0200", digits); end
    n_tests++; if ({running, time_up, expired_pulse, warn} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {running, time_up, expired_pulse, warn}); end
    n_tests++; if (s_digits !== 16'h9955) begin n_fail++; $display("FAIL reset_preload_s got %h want 9955", s_digits); end
    @(negedge clk_25MHz) reset = 1'b0;
    seconds(2);
    n_tests++; if (digits !== 16'h0200 || running !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_ticks got %h run=%b want 0200 run=0", digits, running); end
  endtask

  task automatic test_borrow();
    pulse_start();
    n_tests++; if (running !== 1'b1 || digits !== 16'h0200) begin n_fail++; $display("FAIL start_load got %h run=%b want 0200 run=1", digits, running); end
    one_second();
    n_tests++; if (digits !== 16'h0159) begin n_fail++; $display("FAIL borrow_minute got %h want 0159", digits); end
  endtask

  task automatic test_reset_mid_run();
    seconds(36);
    n_tests++; if (digits !== 16'h0123) begin n_fail++; $display("FAIL count_to_0123 got %h want 0123", digits); end
    @(negedge clk_25MHz) reset = 1'b1;
    #5;
    n_tests++; if (digits !== 16'h0200 || {running, time_up, expired_pulse, warn} !== 4'b0000) begin n_fail++; $display("FAIL async_reset got %h flags=%b want 0200 flags=0000", digits, {running, time_up, expired_pulse, warn}); end
    @(negedge clk_25MHz) reset = 1'b0;
    repeat (4) @(negedge clk_25MHz);
    seconds(3);
    n_tests++; if (digits !== 16'h0200 || running !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got %h run=%b want 0200 run=0", digits, running); end
  endtask

  task automatic test_pause_bonus();
    pulse_start();
    seconds(115);
    n_tests++; if (digits !== 16'h0005) begin n_fail++; $display("FAIL count_to_0005 got %h want 0005", digits); end
    pulse_pause();
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running got %b want 0", running); end
    seconds(4);
    n_tests++; if (digits !== 16'h0005) begin n_fail++; $display("FAIL pause_holds got %h want 0005", digits); end
    pulse_bonus();
    n_tests++; if (digits !== 16'h0015) begin n_fail++; $display("FAIL pause_bonus got %h want 0015", digits); end
    pulse_pause();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running got %b want 1", running); end
    one_second();
    n_tests++; if (digits !== 16'h0014 || warn !== 1'b0) begin n_fail++; $display("FAIL resume_tick got %h warn=%b want 0014 warn=0", digits, warn); end
  endtask

  task automatic test_warn();
    seconds(3);
    n_tests++; if (digits !== 16'h0011 || warn !== 1'b0) begin n_fail++; $display("FAIL warn_0011 got %h warn=%b want 0011 warn=0", digits, warn); end
    one_second();
    n_tests++; if (digits !== 16'h0010 || warn !== WARN_ON) begin n_fail++; $display("FAIL warn_0010 got %h warn=%b want 0010 warn=%b", digits, warn, WARN_ON); end
  endtask

  task automatic test_tick_bonus();
    bit seen = 1'b0;
    seconds(9);
    n_tests++; if (digits !== 16'h0001) begin n_fail++; $display("FAIL count_to_0001 got %h want 0001", digits); end
    @(negedge clk_25MHz) sec_toggle = ~sec_toggle;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_25MHz);
      if (dut.w_tick === 1'b1) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL tick_timeout got 0 want 1"); end
    bonus = 1'b1;
    @(negedge clk_25MHz) bonus = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    n_tests++; if (digits !== 16'h0010 || time_up !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL tick_plus_bonus got %h up=%b run=%b want 0010 up=0 run=1", digits, time_up, running); end
  endtask

  task automatic test_expire();
    bit seen = 1'b0;
    seconds(9);
    @(negedge clk_25MHz) sec_toggle = ~sec_toggle;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_25MHz);
      if (time_up === 1'b1) seen = 1'b1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL expire_timeout got 0 want 1"); end
    n_tests++; if (digits !== 16'h0000 || expired_pulse !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL expire_entry got %h pulse=%b run=%b want 0000 pulse=1 run=0", digits, expired_pulse, running); end
    @(negedge clk_25MHz);
    n_tests++; if (expired_pulse !== 1'b0 || time_up !== 1'b1) begin n_fail++; $display("FAIL expire_pulse_width got pulse=%b up=%b want pulse=0 up=1", expired_pulse, time_up); end
    pulse_bonus();
    one_second();
    n_tests++; if (digits !== 16'h0000 || time_up !== 1'b1 || warn !== 1'b0) begin n_fail++; $display("FAIL expired_holds got %h up=%b warn=%b want 0000 up=1 warn=0", digits, time_up, warn); end
    pulse_start();
    n_tests++; if (digits !== 16'h0200 || running !== 1'b1 || time_up !== 1'b0) begin n_fail++; $display("FAIL restart got %h run=%b up=%b want 0200 run=1 up=0", digits, running, time_up); end
  endtask

  task automatic test_zero_preload();
    @(negedge clk_25MHz) start_z = 1'b1;
    @(negedge clk_25MHz) start_z = 1'b0;
    n_tests++; if (z_digits !== 16'h0000 || z_running !== 1'b1 || z_time_up !== 1'b0) begin n_fail++; $display("FAIL zero_start got %h run=%b up=%b want 0000 run=1 up=0", z_digits, z_running, z_time_up); end
    one_second();
    n_tests++; if (z_digits !== 16'h0000 || z_time_up !== 1'b1 || z_running !== 1'b0) begin n_fail++; $display("FAIL zero_expire got %h up=%b run=%b want 0000 up=1 run=0", z_digits, z_time_up, z_running); end
  endtask

  task automatic test_saturate();
    @(negedge clk_25MHz) start_s = 1'b1;
    @(negedge clk_25MHz) start_s = 1'b0;
    @(negedge clk_25MHz) bonus_s = 1'b1;
    @(negedge clk_25MHz) bonus_s = 1'b0;
    n_tests++; if (s_digits !== 16'h9959) begin n_fail++; $display("FAIL saturate got %h want 9959", s_digits); end
    one_second();
    n_tests++; if (s_digits !== 16'h9958) begin n_fail++; $display("FAIL sat_then_tick got %h want 9958", s_digits); end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_reset_mid_run();
    test_pause_bonus();
    test_warn();
    test_tick_bonus();
    test_expire();
    test_zero_preload();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
